// File: rtl/mips32_pkg.sv
// Shared decode constants for the mips32 R-type datapath.
// Optional feature: define MIPS32_SRA_EN to enable funct 0x03 (sra).
package mips32_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // True for every funct this build executes; anything else is a no-op.
  function automatic logic funct_supported(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: ok = 1'b1;
`ifdef MIPS32_SRA_EN
      FN_SRA:                                 ok = 1'b1;
`endif
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational R-type ALU; signed overflow is flagged for add/sub only.
// Optional feature: define MIPS32_SRA_EN to enable funct 0x03 (sra).
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  output logic [31:0] result,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (funct)
      FN_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      FN_ADDU: result = sum;
      FN_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      FN_SUBU: result = diff;
      FN_AND:  result = a & b;
      FN_OR:   result = a | b;
      FN_NOR:  result = ~(a | b);
      FN_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      FN_SLTU: result = {31'd0, a < b};
      FN_SLL:  result = b << shamt;
      FN_SRL:  result = b >> shamt;
`ifdef MIPS32_SRA_EN
      FN_SRA:  result = $signed(b) >>> shamt;
`endif
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips32.sv
// Single-cycle R-type core: 32x32 register file plus mips32_alu.
// Optional feature: define MIPS32_SRA_EN to enable funct 0x03 (sra).
module mips32
  import mips32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] result,
  output logic        overflow
);

  logic [31:0] regs [REG_N];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        valid;
  logic        write_en;

  assign opcode = instruction[OPCODE_MSB:OPCODE_LSB];
  assign rs     = instruction[RS_MSB:RS_LSB];
  assign rt     = instruction[RT_MSB:RT_LSB];
  assign rd     = instruction[RD_MSB:RD_LSB];
  assign shamt  = instruction[SHAMT_MSB:SHAMT_LSB];
  assign funct  = instruction[FUNCT_MSB:FUNCT_LSB];

  assign rs_val = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? '0 : regs[rt];

  mips32_alu u_alu (
    .a        (rs_val),
    .b        (rt_val),
    .shamt    (shamt),
    .funct    (funct),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  assign valid    = (opcode == OP_RTYPE) && funct_supported(funct);
  assign result   = valid ? alu_result : '0;
  assign overflow = valid & alu_overflow;

  // Overflowing add/sub and writes to r0 are dropped; result still shows the value.
  assign write_en = valid && !overflow && (rd != 5'd0);

  // Every register resets to its own index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= 32'(i);
      end
    end else if (write_en) begin
      regs[rd] <= result;
    end
  end

endmodule

// File: tb/tb_mips32.sv
// Directed self-checking bench for mips32; registers are observed through
// "or rd=0, rs=N, rt=0" reads so only the top-level ports are used.
module tb_mips32;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] result;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  mips32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .result      (result),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {6'h00, rs, rt, rd, shamt, funct};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive a new instruction just after the falling edge; the preceding
  // rising edge has already committed the previous one.
  task automatic applyStimulus(input logic [31:0] instr);
    @(negedge clk);
    instruction = instr;
    #1;
  endtask

  task automatic readReg(input string tag, input logic [4:0] idx,
                         input logic [31:0] expected);
    applyStimulus(rtype(idx, 5'd0, 5'd0, 5'd0, 6'h25));
    checkOutput(tag, result, expected);
  endtask

  logic [31:0] sra_result;
  logic [31:0] sra_reg;

  initial begin
    rst_n       = 1'b0;
    instruction = 32'h0;

    readReg("reset_r9", 5'd9, 32'd9);
    readReg("reset_r31", 5'd31, 32'd31);
    readReg("reset_r0", 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'h00434820);
    checkOutput("add_r9_result", result, 32'd5);
    checkOutput("add_r9_ovf", {31'd0, overflow}, 32'd0);
    readReg("r9_written", 5'd9, 32'd5);

    applyStimulus(32'h00430020);
    checkOutput("add_r0_result", result, 32'd5);
    readReg("r0_stays_zero", 5'd0, 32'd0);

    applyStimulus(32'h00435824);
    checkOutput("and", result, 32'd2);
    applyStimulus(32'h00436825);
    checkOutput("or", result, 32'd3);
    applyStimulus(32'h00436027);
    checkOutput("nor", result, 32'hFFFFFFFC);
    applyStimulus(32'h0043A022);
    checkOutput("sub_r2_r3", result, 32'hFFFFFFFF);
    checkOutput("sub_r2_r3_ovf", {31'd0, overflow}, 32'd0);
    applyStimulus(32'h0062B022);
    checkOutput("sub_r3_r2", result, 32'd1);
    readReg("r20_written", 5'd20, 32'hFFFFFFFF);

    applyStimulus(32'h0043702B);
    checkOutput("sltu_2_3", result, 32'd1);
    applyStimulus(32'h0062782B);
    checkOutput("sltu_3_2", result, 32'd0);
    applyStimulus(rtype(5'd20, 5'd1, 5'd16, 5'd0, 6'h2A));
    checkOutput("slt_neg1_1", result, 32'd1);
    applyStimulus(rtype(5'd1, 5'd20, 5'd16, 5'd0, 6'h2A));
    checkOutput("slt_1_neg1", result, 32'd0);
    applyStimulus(rtype(5'd20, 5'd1, 5'd16, 5'd0, 6'h2B));
    checkOutput("sltu_big_1", result, 32'd0);

    applyStimulus(32'h005F80C0);
    checkOutput("sll_31_3", result, 32'd248);
    applyStimulus(32'h005F88C2);
    checkOutput("srl_31_3", result, 32'd3);

    applyStimulus(rtype(5'd0, 5'd31, 5'd5, 5'd26, 6'h00));
    checkOutput("sll_31_26", result, 32'h7C000000);
    applyStimulus(rtype(5'd5, 5'd5, 5'd6, 5'd0, 6'h20));
    checkOutput("add_ovf_result", result, 32'hF8000000);
    checkOutput("add_ovf_flag", {31'd0, overflow}, 32'd1);
    readReg("r6_not_written", 5'd6, 32'd6);
    applyStimulus(rtype(5'd5, 5'd5, 5'd6, 5'd0, 6'h21));
    checkOutput("addu_result", result, 32'hF8000000);
    checkOutput("addu_no_ovf", {31'd0, overflow}, 32'd0);
    readReg("r6_addu_written", 5'd6, 32'hF8000000);

    applyStimulus(rtype(5'd6, 5'd5, 5'd7, 5'd0, 6'h22));
    checkOutput("sub_ovf_result", result, 32'h7C000000);
    checkOutput("sub_ovf_flag", {31'd0, overflow}, 32'd1);
    readReg("r7_not_written", 5'd7, 32'd7);
    applyStimulus(rtype(5'd6, 5'd5, 5'd7, 5'd0, 6'h23));
    checkOutput("subu_no_ovf", {31'd0, overflow}, 32'd0);
    readReg("r7_subu_written", 5'd7, 32'h7C000000);

    applyStimulus({6'h08, 5'd2, 5'd3, 5'd8, 5'd0, 6'h20});
    checkOutput("opcode8_result", result, 32'd0);
    checkOutput("opcode8_ovf", {31'd0, overflow}, 32'd0);
    readReg("r8_not_written", 5'd8, 32'd8);
    applyStimulus(rtype(5'd2, 5'd3, 5'd8, 5'd0, 6'h01));
    checkOutput("funct1_result", result, 32'd0);

`ifdef MIPS32_SRA_EN
    sra_result = 32'hFF800000;
    sra_reg    = 32'hFF800000;
`else
    sra_result = 32'd0;
    sra_reg    = 32'd10;
`endif
    applyStimulus(rtype(5'd0, 5'd6, 5'd10, 5'd4, 6'h03));
    checkOutput("sra_result", result, sra_result);
    readReg("r10_after_sra", 5'd10, sra_reg);

    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    instruction = rtype(5'd2, 5'd3, 5'd9, 5'd0, 6'h21);
    #1;
    checkOutput("reset_comb_result", result, 32'd5);
    readReg("midreset_r6", 5'd6, 32'd6);
    readReg("midreset_r9", 5'd9, 32'd9);
    readReg("midreset_r5", 5'd5, 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    readReg("after_reset_r7", 5'd7, 32'd7);
    readReg("after_reset_r20", 5'd20, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips32.md
MIPS32 -- requirements
Module: mips32

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and the register count at 32.
REQ-002 clk  input  1  single clock; register-file writes occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instruction  input  32  R-type instruction to execute this cycle.
REQ-005 result  output  32  combinational ALU result of the current instruction.
REQ-006 overflow  output  1  combinational; high when an add/sub (funct 0x20/0x22) overflows in signed arithmetic.

Function
REQ-007 Decode SHALL use opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6] and funct[5:0].
REQ-008 With opcode==0, result SHALL be computed as follows:
- add 0x20 / addu 0x21: rs+rt
- sub 0x22 / subu 0x23: rs-rt
- and 0x24: rs&rt
- or 0x25: rs|rt
- nor 0x27: ~(rs|rt)
- slt 0x2A: signed rs<rt ? 1 : 0
- sltu 0x2B: unsigned rs<rt ? 1 : 0
- sll 0x00: rt<<shamt
- srl 0x02: rt>>shamt, zero-fill
REQ-009 All arithmetic SHALL be modulo 2^32; the rs field is ignored for shifts.
REQ-010 result and overflow SHALL depend only on instruction and current register contents (zero-latency combinational path).
REQ-011 On the rising edge of clk with rst_n high, the block SHALL write result to register rd for every supported funct, except as stated in REQ-012.
REQ-012 add/sub with signed overflow SHALL suppress the write; result still shows the wrapped value and overflow=1. addu/subu never flag overflow.
REQ-013 Register 0 SHALL always read 0; writes to rd=0 SHALL be discarded, but result still shows the computed value.
REQ-014 A nonzero opcode or an unsupported funct SHALL drive result=0 and overflow=0, and SHALL perform no write.
REQ-015 Reading a register written in the previous cycle SHALL return the new value.

Reset
REQ-016 When rst_n is low, every register i SHALL asynchronously load the value i (r0=0, r2=2, r3=3, r31=31).
REQ-017 No writes SHALL occur while rst_n is low; result remains combinational during reset.
REQ-018 Deasserting rst_n mid-run SHALL take effect at the next rising edge of clk with no partial write.

Configuration
REQ-019 With macro MIPS32_SRA_EN defined, funct 0x03 (sra) SHALL compute the arithmetic shift rt>>>shamt and write rd.
REQ-020 Without MIPS32_SRA_EN, funct 0x03 SHALL be treated as unsupported per REQ-014.

Structure
REQ-021 The shared package mips32_pkg SHALL hold:
- funct code constants
- instruction-field bit positions
- the opcode value for R-type (0)
REQ-022 The ALU SHALL be a sub-module named mips32_alu, with inputs a, b, shamt and funct and outputs result and overflow.
REQ-023 The register file (two combinational read ports, one write port) SHALL reside in the top-level mips32 module.

Verification
REQ-024 Reset, then apply add rd=9 (0x00434820) -> result=5; after the clock edge, r9=5. Then add rd=0 (0x00430020) -> result=5; r0 reads 0 afterwards.
REQ-025 Apply the following and check result:
- and (0x00435824) -> 2
- or (0x00436825) -> 3
- nor (0x00436027) -> 0xFFFFFFFC
- sub r2-r3 (0x0043A022) -> 0xFFFFFFFF
- sub r3-r2 (0x0062B022) -> 1
REQ-026 Apply the following and check result:
- sltu r2<r3 (0x0043702B) -> 1
- sltu r3<r2 (0x0062782B) -> 0
- slt with rs=0xFFFFFFFF, rt=1 -> 1
REQ-027 Apply the following and check result:
- sll r31 by 3 (0x005F80C0) -> 248
- srl r31 by 3 (0x005F88C2) -> 3
REQ-028 Overflow case:
- sll r31 by 26 into r5 -> r5 = 0x7C000000
- add r5+r5 into r6 -> result 0xF8000000, overflow=1, r6 keeps 6
- addu of the same operands -> overflow=0, write occurs
REQ-029 Unsupported and reset cases:
- opcode 0x08 -> result 0, no write
- assert rst_n mid-run -> all registers return to value i
